// File: rtl/trace_request_tracker.sv
// In-order tracker for outstanding trace-driven memory requests.
// Responses may arrive out of order; retirements leave in allocation order.
module trace_request_tracker #(
    parameter int ENTRIES     = 8,
    parameter int ADDR_WIDTH  = 32,
    parameter int INDEX_WIDTH = 17,
    parameter int TAG_WIDTH   = $clog2(ENTRIES)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   alloc_valid,
    output logic                   alloc_ready,
    input  logic [ADDR_WIDTH-1:0]  alloc_addr,
    input  logic [INDEX_WIDTH-1:0] alloc_index,
    output logic                   issue_valid,
    input  logic                   issue_ready,
    output logic [ADDR_WIDTH-1:0]  issue_addr,
    output logic [TAG_WIDTH-1:0]   issue_tag,
    input  logic                   resp_valid,
    input  logic [TAG_WIDTH-1:0]   resp_tag,
    input  logic                   resp_hit,
    output logic                   ret_valid,
    input  logic                   ret_ready,
    output logic [INDEX_WIDTH-1:0] ret_index,
    output logic [ADDR_WIDTH-1:0]  ret_addr,
    output logic                   ret_hit,
    output logic [TAG_WIDTH:0]     occupancy,
    output logic                   resp_err
);

    typedef enum logic [1:0] {
        FREE,
        MAKE_REQUEST,
        WAIT_FOR_PROCESSING,
        REQUEST_RETIRED
    } slot_state_e;

    localparam logic [TAG_WIDTH:0]   FULL    = (TAG_WIDTH+1)'(ENTRIES);
    localparam logic [TAG_WIDTH:0]   OCC_ONE = (TAG_WIDTH+1)'(1);
    localparam logic [TAG_WIDTH-1:0] TAG_ONE = TAG_WIDTH'(1);

    slot_state_e            state_q [ENTRIES];
    slot_state_e            state_d [ENTRIES];
    logic [ADDR_WIDTH-1:0]  addr_q  [ENTRIES];
    logic [ADDR_WIDTH-1:0]  addr_d  [ENTRIES];
    logic [INDEX_WIDTH-1:0] index_q [ENTRIES];
    logic [INDEX_WIDTH-1:0] index_d [ENTRIES];
    logic                   hit_q   [ENTRIES];
    logic                   hit_d   [ENTRIES];

    logic [TAG_WIDTH-1:0] tail_q, tail_d;
    logic [TAG_WIDTH-1:0] issue_q, issue_d;
    logic [TAG_WIDTH-1:0] head_q, head_d;
    logic [TAG_WIDTH:0]   occ_q, occ_d;
    logic                 err_q, err_d;

    logic alloc_fire;
    logic issue_fire;
    logic pop_fire;

    assign alloc_ready = rst_n && (occ_q != FULL);
    assign issue_valid = (state_q[issue_q] == MAKE_REQUEST);
    assign issue_addr  = addr_q[issue_q];
    assign issue_tag   = issue_q;
    assign ret_valid   = (state_q[head_q] == REQUEST_RETIRED);
    assign ret_index   = index_q[head_q];
    assign ret_addr    = addr_q[head_q];
    assign ret_hit     = hit_q[head_q];
    assign occupancy   = occ_q;
    assign resp_err    = err_q;

    assign alloc_fire = alloc_valid && alloc_ready;
    assign issue_fire = issue_valid && issue_ready;
    assign pop_fire   = ret_valid && ret_ready;

    // The four events always target distinct slots, so they compose freely.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        index_d = index_q;
        hit_d   = hit_q;
        tail_d  = tail_q;
        issue_d = issue_q;
        head_d  = head_q;
        occ_d   = occ_q;
        err_d   = err_q;

        if (alloc_fire) begin
            state_d[tail_q] = MAKE_REQUEST;
            addr_d[tail_q]  = alloc_addr;
            index_d[tail_q] = alloc_index;
            hit_d[tail_q]   = 1'b0;
            tail_d          = tail_q + TAG_ONE;
        end

        if (issue_fire) begin
            state_d[issue_q] = WAIT_FOR_PROCESSING;
            issue_d          = issue_q + TAG_ONE;
        end

        if (resp_valid) begin
            if (state_q[resp_tag] == WAIT_FOR_PROCESSING) begin
                state_d[resp_tag] = REQUEST_RETIRED;
                hit_d[resp_tag]   = resp_hit;
            end else begin
                err_d = 1'b1;
            end
        end

        if (pop_fire) begin
            state_d[head_q] = FREE;
            head_d          = head_q + TAG_ONE;
        end

        if (alloc_fire && !pop_fire) begin
            occ_d = occ_q + OCC_ONE;
        end else if (!alloc_fire && pop_fire) begin
            occ_d = occ_q - OCC_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= FREE;
                addr_q[i]  <= '0;
                index_q[i] <= '0;
                hit_q[i]   <= 1'b0;
            end
            tail_q  <= '0;
            issue_q <= '0;
            head_q  <= '0;
            occ_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            index_q <= index_d;
            hit_q   <= hit_d;
            tail_q  <= tail_d;
            issue_q <= issue_d;
            head_q  <= head_d;
            occ_q   <= occ_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_trace_request_tracker.sv
// Scoreboard bench for trace_request_tracker with ENTRIES=4.
// Directed stimulus; issue and retirement streams checked by a monitor.
module tb_trace_request_tracker;

    localparam int E  = 4;
    localparam int AW = 32;
    localparam int IW = 17;
    localparam int TW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          alloc_valid;
    logic          alloc_ready;
    logic [AW-1:0] alloc_addr;
    logic [IW-1:0] alloc_index;
    logic          issue_valid;
    logic          issue_ready;
    logic [AW-1:0] issue_addr;
    logic [TW-1:0] issue_tag;
    logic          resp_valid;
    logic [TW-1:0] resp_tag;
    logic          resp_hit;
    logic          ret_valid;
    logic          ret_ready;
    logic [IW-1:0] ret_index;
    logic [AW-1:0] ret_addr;
    logic          ret_hit;
    logic [TW:0]   occupancy;
    logic          resp_err;

    trace_request_tracker #(
        .ENTRIES(E), .ADDR_WIDTH(AW), .INDEX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
        .alloc_addr(alloc_addr), .alloc_index(alloc_index),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_addr(issue_addr), .issue_tag(issue_tag),
        .resp_valid(resp_valid), .resp_tag(resp_tag),
        .resp_hit(resp_hit),
        .ret_valid(ret_valid), .ret_ready(ret_ready),
        .ret_index(ret_index), .ret_addr(ret_addr),
        .ret_hit(ret_hit),
        .occupancy(occupancy), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [IW-1:0] idx;
        logic          hit;
        logic [TW-1:0] tag;
    } exp_t;

    exp_t iss_q[$];
    exp_t ret_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue and retire streams are compared here, independent of stimulus.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            if (iss_q.size() == 0) begin
                chk("issue_unexpected", 64'(issue_addr), 64'hdead);
            end else begin
                exp_t e;
                e = iss_q.pop_front();
                chk("issue_addr", 64'(issue_addr), 64'(e.addr));
                chk("issue_tag", 64'(issue_tag), 64'(e.tag));
            end
        end
        if (rst_n && ret_valid && ret_ready) begin
            if (ret_q.size() == 0) begin
                chk("ret_unexpected", 64'(ret_index), 64'hdead);
            end else begin
                exp_t e;
                e = ret_q.pop_front();
                chk("ret_index", 64'(ret_index), 64'(e.idx));
                chk("ret_addr", 64'(ret_addr), 64'(e.addr));
                chk("ret_hit", 64'(ret_hit), 64'(e.hit));
            end
        end
    end

    task automatic expect_req(input logic [AW-1:0] a, input int idx,
                              input logic h, input int tag);
        exp_t e;
        e.addr = a;
        e.idx  = IW'(idx);
        e.hit  = h;
        e.tag  = TW'(tag);
        iss_q.push_back(e);
        ret_q.push_back(e);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        alloc_valid = 1'b0;
        alloc_addr  = '0;
        alloc_index = '0;
        issue_ready = 1'b0;
        resp_valid  = 1'b0;
        resp_tag    = '0;
        resp_hit    = 1'b0;
        ret_ready   = 1'b0;
        iss_q.delete();
        ret_q.delete();
        step();
        chk("rst_occupancy", 64'(occupancy), 64'd0);
        chk("rst_issue_valid", 64'(issue_valid), 64'd0);
        chk("rst_ret_valid", 64'(ret_valid), 64'd0);
        chk("rst_alloc_ready", 64'(alloc_ready), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        chk("rst_issue_addr", 64'(issue_addr), 64'd0);
        chk("rst_ret_index", 64'(ret_index), 64'd0);
        step();
        rst_n = 1'b1;
        #1;
        chk("post_rst_alloc_ready", 64'(alloc_ready), 64'd1);
    endtask

    task automatic respond(input int tag, input logic h);
        resp_valid = 1'b1;
        resp_tag   = TW'(tag);
        resp_hit   = h;
        step();
        resp_valid = 1'b0;
    endtask

    initial begin
        do_reset();

        // Single request round trip.
        ret_ready   = 1'b1;
        alloc_valid = 1'b1;
        alloc_addr  = 32'h100;
        alloc_index = 17'd5;
        expect_req(32'h100, 5, 1'b1, 0);
        step();
        alloc_valid = 1'b0;
        chk("t1_issue_latency", 64'(issue_valid), 64'd1);
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t1_issue_done", 64'(issue_valid), 64'd0);
        respond(0, 1'b1);
        chk("t1_ret_latency", 64'(ret_valid), 64'd1);
        step();
        chk("t1_occ_zero", 64'(occupancy), 64'd0);
        chk("t1_ret_gone", 64'(ret_valid), 64'd0);

        // Fill, out-of-order responses, pop with simultaneous alloc.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            alloc_addr  = 32'h200 + 32'(i * 4);
            alloc_index = IW'(i);
            expect_req(alloc_addr, i, (i == 0 || i == 3), i);
            step();
        end
        chk("t2_full_occ", 64'(occupancy), 64'd4);
        chk("t2_full_ready", 64'(alloc_ready), 64'd0);
        alloc_addr  = 32'h210;
        alloc_index = 17'd4;
        issue_ready = 1'b1;
        step();
        step();
        step();
        issue_ready = 1'b0;
        chk("t2_held_occ", 64'(occupancy), 64'd4);
        chk("t2_held_ready", 64'(alloc_ready), 64'd0);
        respond(2, 1'b0);
        chk("t3_head_blocks", 64'(ret_valid), 64'd0);
        respond(0, 1'b1);
        chk("t3_head_ret", 64'(ret_valid), 64'd1);
        ret_ready = 1'b1;
        respond(1, 1'b0);
        chk("t2_after_pop_occ", 64'(occupancy), 64'd3);
        chk("t2_after_pop_ready", 64'(alloc_ready), 64'd1);
        expect_req(32'h210, 4, 1'b0, 0);
        step();
        alloc_valid = 1'b0;
        chk("t2_alloc_pop_occ", 64'(occupancy), 64'd3);
        step();
        chk("t2_drain_occ", 64'(occupancy), 64'd2);
        issue_ready = 1'b1;
        step();
        step();
        issue_ready = 1'b0;
        respond(3, 1'b1);
        respond(0, 1'b0);
        step();
        step();
        chk("t2_empty_occ", 64'(occupancy), 64'd0);

        // Issue stall: request must hold steady until accepted.
        alloc_valid = 1'b1;
        alloc_addr  = 32'h300;
        alloc_index = 17'd7;
        expect_req(32'h300, 7, 1'b1, 1);
        step();
        alloc_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_stall_valid", 64'(issue_valid), 64'd1);
            chk("t4_stall_addr", 64'(issue_addr), 64'h300);
            step();
        end
        issue_ready = 1'b1;
        step();
        issue_ready = 1'b0;
        chk("t4_once", 64'(issue_valid), 64'd0);
        respond(1, 1'b1);
        step();
        chk("t4_occ", 64'(occupancy), 64'd0);

        // Response to a FREE slot.
        respond(3, 1'b1);
        chk("t5_free_err", 64'(resp_err), 64'd1);
        chk("t5_free_occ", 64'(occupancy), 64'd0);
        chk("t5_free_ret", 64'(ret_valid), 64'd0);
        step();
        step();
        chk("t5_err_sticky", 64'(resp_err), 64'd1);

        // Response in the issue-handshake cycle.
        do_reset();
        alloc_valid = 1'b1;
        alloc_addr  = 32'h400;
        alloc_index = 17'd9;
        expect_req(32'h400, 9, 1'b1, 0);
        step();
        alloc_valid = 1'b0;
        issue_ready = 1'b1;
        respond(0, 1'b0);
        issue_ready = 1'b0;
        chk("t5_hs_err", 64'(resp_err), 64'd1);
        chk("t5_hs_noret", 64'(ret_valid), 64'd0);
        step();
        chk("t5_hs_still_wait", 64'(ret_valid), 64'd0);
        respond(0, 1'b1);
        chk("t5_hs_ret", 64'(ret_valid), 64'd1);
        ret_ready = 1'b1;
        step();
        ret_ready = 1'b0;
        chk("t5_hs_occ", 64'(occupancy), 64'd0);
        chk("t5_hs_err_kept", 64'(resp_err), 64'd1);

        // Reset with slots outstanding.
        for (int i = 0; i < 3; i++) begin
            alloc_valid = 1'b1;
            alloc_addr  = 32'h500 + 32'(i);
            alloc_index = IW'(10 + i);
            step();
        end
        alloc_valid = 1'b0;
        chk("t6_pre_occ", 64'(occupancy), 64'd3);
        do_reset();
        step();
        chk("t6_occ", 64'(occupancy), 64'd0);
        chk("t6_issue_valid", 64'(issue_valid), 64'd0);

        chk("iss_q_empty", 64'(iss_q.size()), 64'd0);
        chk("ret_q_empty", 64'(ret_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
